// File: rtl/xif_copro_pkg.sv
// Shared types and constants for the XIF coprocessor execution controller.
// Contents: eXtension-interface widths, operation/operand-select enums,
// decoder output, offloaded instruction entry, FU tag, memory-path metadata,
// XIF result payload and the result-arbiter source enum.
package xif_copro_pkg;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFR_WIDTH = 32;
  localparam int X_RFW_WIDTH = 32;
  localparam int X_NUM_RS    = 2;

  typedef enum logic [2:0] {
    COPRO_NOP    = 3'd0,
    COPRO_BITREV = 3'd1,
    COPRO_POPCNT = 3'd2,
    COPRO_CLZ    = 3'd3,
    COPRO_ADD    = 3'd4
  } copro_op_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CPU  = 2'd1,
    OP_REGA = 2'd2,
    OP_REGB = 2'd3
  } op_select_e;

  // Result-register source; also the round-robin pointer encoding.
  typedef enum logic {
    SRC_FU  = 1'b0,
    SRC_MEM = 1'b1
  } arb_src_e;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
  } offloaded_data_t;

  typedef struct packed {
    logic             use_copro;
    copro_op_e        op;
    op_select_e [2:0] op_select;
    logic             rd_is_copro;
  } decoder_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            addr;
    logic                  rd_is_copro;
  } copro_tag_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  dbg;
  } mem_metadata_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic [5:0]             ecsdata;
    logic [2:0]             ecswe;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;

endpackage

// File: rtl/xif_copro_exec_ctrl_if.sv
// Signal bundle of the execution controller.
// Channels: input-stream head (in_*), FU issue (fu_req_*, fu_op/operand/tag),
// FU response (fu_rsp_*), memory-path response (mem_rsp_*), XIF result
// (result_*) and the in-flight counter (outstanding_o).
// Modports: slave = controller view, master = surrounding system view.
//
// Handshakes: every channel transfers on a clock edge where valid and ready
// are both high. Valid may not depend on ready. Ready outputs of the
// controller are combinational and are 0 while the matching valid is 0.
interface xif_copro_exec_ctrl_if
  import xif_copro_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
);

  logic                                     in_valid_i;
  logic                                     in_ready_o;
  offloaded_data_t                          in_data_i;
  decoder_t                                 in_dec_i;
  logic                                     fu_req_valid_o;
  logic                                     fu_req_ready_i;
  copro_op_e                                fu_op_o;
  logic [X_RFR_WIDTH-1:0]                   fu_operand_o;
  copro_tag_t                               fu_tag_o;
  logic                                     fu_rsp_valid_i;
  logic                                     fu_rsp_ready_o;
  logic [X_RFW_WIDTH-1:0]                   fu_rsp_data_i;
  copro_tag_t                               fu_rsp_tag_i;
  logic                                     mem_rsp_valid_i;
  logic                                     mem_rsp_ready_o;
  mem_metadata_t                            mem_rsp_meta_i;
  logic [X_RFW_WIDTH-1:0]                   mem_rsp_data_i;
  logic                                     result_valid_o;
  logic                                     result_ready_i;
  x_result_t                                result_o;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o;

  modport slave (
    input  in_valid_i, in_data_i, in_dec_i, fu_req_ready_i,
           fu_rsp_valid_i, fu_rsp_data_i, fu_rsp_tag_i,
           mem_rsp_valid_i, mem_rsp_meta_i, mem_rsp_data_i, result_ready_i,
    output in_ready_o, fu_req_valid_o, fu_op_o, fu_operand_o, fu_tag_o,
           fu_rsp_ready_o, mem_rsp_ready_o, result_valid_o, result_o,
           outstanding_o
  );

  modport master (
    output in_valid_i, in_data_i, in_dec_i, fu_req_ready_i,
           fu_rsp_valid_i, fu_rsp_data_i, fu_rsp_tag_i,
           mem_rsp_valid_i, mem_rsp_meta_i, mem_rsp_data_i, result_ready_i,
    input  in_ready_o, fu_req_valid_o, fu_op_o, fu_operand_o, fu_tag_o,
           fu_rsp_ready_o, mem_rsp_ready_o, result_valid_o, result_o,
           outstanding_o
  );

endinterface

// File: rtl/xif_copro_result_arb.sv
// Two-source arbiter feeding a single registered XIF result slot.
// Ports: clk/rst (async, active-high); fu_valid/fu_ready/fu_data and
// mem_valid/mem_ready/mem_data are the two valid/ready sources;
// out_valid/out_ready/out_data is the registered result.
// Macro XIF_COPRO_RR_ARB_EN: round-robin between FU and MEM; when undefined
// MEM has fixed priority over FU and no pointer register exists.
module xif_copro_result_arb
  import xif_copro_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      fu_valid,
  output logic      fu_ready,
  input  x_result_t fu_data,
  input  logic      mem_valid,
  output logic      mem_ready,
  input  x_result_t mem_data,
  output logic      out_valid,
  input  logic      out_ready,
  output x_result_t out_data
);

  logic can_load;
  logic grant_fu;
  logic grant_mem;

  // The slot refills in the same cycle it drains, giving one result per cycle.
  assign can_load = ~out_valid | out_ready;

`ifdef XIF_COPRO_RR_ARB_EN
  arb_src_e ptr;

  always_comb begin
    grant_fu  = 1'b0;
    grant_mem = 1'b0;
    if (can_load) begin
      if (fu_valid && mem_valid) begin
        grant_fu  = (ptr == SRC_FU);
        grant_mem = (ptr == SRC_MEM);
      end else begin
        grant_fu  = fu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  // Pointer moves to the side that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRC_FU;
    end else if (grant_fu) begin
      ptr <= SRC_MEM;
    end else if (grant_mem) begin
      ptr <= SRC_FU;
    end
  end
`else
  assign grant_mem = can_load & mem_valid;
  assign grant_fu  = can_load & fu_valid & ~mem_valid;
`endif

  assign fu_ready  = grant_fu;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (can_load) begin
      out_valid <= grant_fu | grant_mem;
      if (grant_mem) begin
        out_data <= mem_data;
      end else if (grant_fu) begin
        out_data <= fu_data;
      end
    end
  end

endmodule

// File: rtl/xif_copro_exec_ctrl.sv
// XIF coprocessor execution controller (top).
// Dispatches decoded input-stream entries to the FU with a tag, bounds the
// number of in-flight FU operations, and merges FU and memory-path results
// into the single XIF result port through xif_copro_result_arb.
// Ports: clk_i, rst_i (async, active-high); bus (xif_copro_exec_ctrl_if.slave)
// carrying all stream, FU, memory and result channels plus outstanding_o.
// Macro XIF_COPRO_RR_ARB_EN selects round-robin result arbitration
// (default: MEM has fixed priority over FU).
module xif_copro_exec_ctrl
  import xif_copro_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
)
(
  input logic                   clk_i,
  input logic                   rst_i,
  xif_copro_exec_ctrl_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]       count;
  logic                   can_issue;
  logic                   fu_req_valid;
  logic                   issue_hs;
  logic                   rsp_hs;
  logic                   stale_rsp_ok;
  logic [X_RFR_WIDTH-1:0] operand;
  x_result_t              fu_result;
  x_result_t              mem_result;
  logic                   unused_bits;

  // Gated on the registered count: a response in the same cycle does not
  // free a slot until the next cycle.
  assign can_issue    = count < MAX_CNT;
  assign fu_req_valid = bus.in_valid_i & bus.in_dec_i.use_copro & can_issue;
  assign issue_hs     = fu_req_valid & bus.fu_req_ready_i;
  assign rsp_hs       = bus.fu_rsp_valid_i & bus.fu_rsp_ready_o;

  // Non-coprocessor entries are dropped here; the memory path returns them.
  assign bus.in_ready_o     = bus.in_valid_i & (~bus.in_dec_i.use_copro | issue_hs);
  assign bus.fu_req_valid_o = fu_req_valid;
  assign bus.fu_op_o        = bus.in_dec_i.op;
  assign bus.fu_operand_o   = operand;
  assign bus.fu_tag_o       = {bus.in_data_i.id, bus.in_data_i.instr[11:7],
                               bus.in_dec_i.rd_is_copro};
  assign bus.outstanding_o  = count;

  always_comb begin
    operand = '0;
    case (bus.in_dec_i.op_select[0])
      OP_REGA, OP_CPU: operand = bus.in_data_i.rs[0];
      OP_REGB:         operand = bus.in_data_i.rs[1];
      default:         operand = '0;
    endcase
  end

  // Responses for operations issued before a reset may still arrive; the
  // counter saturates at 0 for them. stale_rsp_ok marks that window (from
  // reset until the first new issue) so those are not flagged as underflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count        <= '0;
      stale_rsp_ok <= 1'b1;
    end else begin
      if (issue_hs) begin
        stale_rsp_ok <= 1'b0;
      end
      if (issue_hs && !rsp_hs) begin
        count <= count + 1'b1;
      end else if (rsp_hs && !issue_hs && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_hs && !issue_hs && (count == '0) && !stale_rsp_ok));

  always_comb begin
    fu_result      = '0;
    fu_result.id   = bus.fu_rsp_tag_i.id;
    fu_result.data = bus.fu_rsp_data_i;
    fu_result.rd   = bus.fu_rsp_tag_i.addr;
    fu_result.we   = ~bus.fu_rsp_tag_i.rd_is_copro;
  end

  always_comb begin
    mem_result         = '0;
    mem_result.id      = bus.mem_rsp_meta_i.id;
    mem_result.data    = bus.mem_rsp_data_i;
    mem_result.rd      = bus.mem_rsp_meta_i.rd;
    mem_result.we      = bus.mem_rsp_meta_i.we;
    mem_result.exc     = bus.mem_rsp_meta_i.exc;
    mem_result.exccode = bus.mem_rsp_meta_i.exccode;
    mem_result.dbg     = bus.mem_rsp_meta_i.dbg;
  end

  xif_copro_result_arb u_result_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .fu_valid  (bus.fu_rsp_valid_i),
    .fu_ready  (bus.fu_rsp_ready_o),
    .fu_data   (fu_result),
    .mem_valid (bus.mem_rsp_valid_i),
    .mem_ready (bus.mem_rsp_ready_o),
    .mem_data  (mem_result),
    .out_valid (bus.result_valid_o),
    .out_ready (bus.result_ready_i),
    .out_data  (bus.result_o)
  );

  // Instruction bits outside rd and the secondary operand selects are
  // consumed by the decoder, not here.
  assign unused_bits = ^{bus.in_data_i.instr[31:12], bus.in_data_i.instr[6:0],
                         bus.in_dec_i.op_select[2:1]};

endmodule
